// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : config_pkg
//  Brief    : Shared constants, state encoding and helpers for the fabric
//             configuration word stream transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package config_pkg;

  localparam int NumberOfRows    = 20;
  localparam int desync_flag     = 20;
  localparam int MemAddrWidth    = 12;
  localparam int FrameCountWidth = 8;
  localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;

  // One header word plus one word per fabric row
  localparam int FrameWords = NumberOfRows + 1;
  // Row counter must hold 0..NumberOfRows
  localparam int RowWidth   = $clog2(FrameWords);

  // Terminating word: all zero except the desync flag
  localparam logic [31:0] DesyncWord = 32'h1 << desync_flag;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RSTP   = 3'd1,
    GAP    = 3'd2,
    SYNC   = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5,
    DESYNC = 3'd6,
    FIN    = 3'd7
  } state_t;

  // Headers leave memory possibly carrying the desync flag; it must never
  // reach the receiver inside a frame.
  function automatic logic [31:0] strip_desync(input logic [31:0] word);
    strip_desync = word & ~DesyncWord;
  endfunction

endpackage
`default_nettype wire

// File: rtl/config_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : config_frame_reader
//  Brief    : Frame memory read engine. Owns the address pointer, the row and
//             frame counters, read issue, and the header tag that travels
//             alongside each read so it lines up with mem_rdata.
//  Revision : 1.0  initial release
// ============================================================================
module config_frame_reader
  import config_pkg::*;
(
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       load,
  input  logic [MemAddrWidth-1:0]    base_addr,
  input  logic [FrameCountWidth-1:0] frame_count,
  input  logic                       issue_req,
  output logic                       mem_rd_en,
  output logic [MemAddrWidth-1:0]    mem_addr,
  output logic                       last_word,
  output logic                       no_frames,
  output logic                       rd_valid,
  output logic                       rd_is_header
);

  logic [MemAddrWidth-1:0]    ptr;
  logic [RowWidth-1:0]        row;
  logic [FrameCountWidth-1:0] frames_left;
  logic                       row_last;

  assign row_last  = (row == RowWidth'(NumberOfRows));
  assign no_frames = (frames_left == '0);
  // Never read past the final frame even if the FSM keeps requesting
  assign mem_rd_en = issue_req && !no_frames;
  assign mem_addr  = ptr;
  // The read issued this cycle is the final row of the final frame
  assign last_word = row_last && (frames_left == FrameCountWidth'(1));

  // Pointer and counters: load on accepted start, advance once per read
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      ptr         <= '0;
      row         <= '0;
      frames_left <= '0;
    end else if (load) begin
      ptr         <= base_addr;
      row         <= '0;
      frames_left <= frame_count;
    end else if (mem_rd_en) begin
      // Natural overflow gives the modulo-2^MemAddrWidth wrap
      ptr <= ptr + MemAddrWidth'(1);
      if (row_last) begin
        row         <= '0;
        frames_left <= frames_left - FrameCountWidth'(1);
      end else begin
        row <= row + RowWidth'(1);
      end
    end
  end

  // Tag pipeline: valid/header flags aligned with the cycle mem_rdata is valid
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rd_valid     <= 1'b0;
      rd_is_header <= 1'b0;
    end else begin
      rd_valid     <= mem_rd_en;
      rd_is_header <= mem_rd_en && (row == '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/config_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : config_stream_tx
//  Brief    : Transmit end of the fabric configuration word protocol. Emits
//             FSM_Reset, sync word, frames read from memory, and desync word
//             as a registered WriteData/WriteStrobe stream.
//  Revision : 1.0  initial release
// ============================================================================
module config_stream_tx
  import config_pkg::*;
(
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [MemAddrWidth-1:0]    base_addr,
  input  logic [FrameCountWidth-1:0] frame_count,
  input  logic                       abort,
  input  logic                       out_ready,
  output logic                       mem_rd_en,
  output logic [MemAddrWidth-1:0]    mem_addr,
  input  logic [31:0]                mem_rdata,
  output logic                       FSM_Reset,
  output logic [31:0]                WriteData,
  output logic                       WriteStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted
);

  state_t state, state_nxt;
  logic   abort_flag;
  logic   abort_set;
  logic   accept;
  logic   issue_req;
  logic   last_word;
  logic   no_frames;
  logic   rd_valid;
  logic   rd_is_header;

  assign accept    = (state == IDLE) && start;
  assign issue_req = (state == STREAM) && out_ready && !abort;

  config_frame_reader u_reader (
    .CLK          (CLK),
    .resetn       (resetn),
    .load         (accept),
    .base_addr    (base_addr),
    .frame_count  (frame_count),
    .issue_req    (issue_req),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .last_word    (last_word),
    .no_frames    (no_frames),
    .rd_valid     (rd_valid),
    .rd_is_header (rd_is_header)
  );

  // State register and sticky abort record for the current transfer
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      abort_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        abort_flag <= 1'b0;
      else if (abort_set)
        abort_flag <= 1'b1;
    end
  end

  // Next-state logic; abort shortcuts to DESYNC (or DRAIN when reads may be in flight)
  always_comb begin
    state_nxt = state;
    abort_set = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = RSTP;
      RSTP:   begin
                if (abort) begin
                  state_nxt = DESYNC;
                  abort_set = 1'b1;
                end else begin
                  state_nxt = GAP;
                end
              end
      GAP:    begin
                if (abort) begin
                  state_nxt = DESYNC;
                  abort_set = 1'b1;
                end else begin
                  state_nxt = SYNC;
                end
              end
      SYNC:   begin
                if (abort) begin
                  state_nxt = DESYNC;
                  abort_set = 1'b1;
                end else if (out_ready) begin
                  state_nxt = no_frames ? DESYNC : STREAM;
                end
              end
      STREAM: begin
                if (abort) begin
                  state_nxt = DRAIN;
                  abort_set = 1'b1;
                end else if (mem_rd_en && last_word) begin
                  state_nxt = DRAIN;
                end
              end
      // The last read's data is captured by the output stage during this
      // cycle, so one cycle is always enough to empty the pipeline.
      DRAIN:  state_nxt = DESYNC;
      DESYNC: if (out_ready) state_nxt = FIN;
      FIN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers: status from the next state, stream word from the read pipeline or SYNC/DESYNC
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FSM_Reset   <= 1'b0;
      WriteData   <= '0;
      WriteStrobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      FSM_Reset   <= (state_nxt == RSTP);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == FIN);
      WriteStrobe <= 1'b0;

      if (accept)
        aborted <= 1'b0;
      else if (state_nxt == FIN)
        aborted <= abort_flag;

      if (rd_valid) begin
        WriteData   <= rd_is_header ? strip_desync(mem_rdata) : mem_rdata;
        WriteStrobe <= 1'b1;
      end else if ((state == SYNC) && out_ready && !abort) begin
        WriteData   <= SyncWord;
        WriteStrobe <= 1'b1;
      end else if ((state == DESYNC) && out_ready) begin
        WriteData   <= DesyncWord;
        WriteStrobe <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
